// File: rtl/imm_ext_pkg.sv
// Shared encodings for the immediate extension unit: mode field and FSM state.
package imm_ext_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    IMM_ZERO = 2'b00,
    IMM_SIGN = 2'b01,
    IMM_HIGH = 2'b10,
    IMM_RSVD = 2'b11
  } imm_mode_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } imm_state_e;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational extender: takes the right-aligned concatenated chunks and a chunk
// count, and produces the zero/sign/high-placed OUT_W result plus overflow flag.
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int IN_W       = 8,
  parameter int OUT_W      = 20,
  parameter int MAX_CHUNKS = 3
) (
  input  logic [IN_W*MAX_CHUNKS-1:0]      v,
  input  logic [$clog2(MAX_CHUNKS+1)-1:0] count,
  input  imm_mode_e                       mode,
  output logic [OUT_W-1:0]                result,
  output logic                            ovf,
  output logic                            rsvd
);

  localparam int VW = IN_W * MAX_CHUNKS;
  localparam int WW = (VW > OUT_W) ? VW : OUT_W;

  int          n;
  logic [WW-1:0] vz;
  logic        sgn;

  always_comb begin
    n   = int'(count) * IN_W;
    vz  = '0;
    sgn = 1'b0;
    // Keep only the n valid bits; capture the sign bit at position n-1.
    for (int i = 0; i < VW; i++) begin
      if (i < n) vz[i] = v[i];
      if (i == n - 1) sgn = v[i];
    end

    result = '0;
    case (mode)
      IMM_SIGN: begin
        for (int i = 0; i < OUT_W; i++) result[i] = (i < n) ? vz[i] : sgn;
      end
      IMM_HIGH: begin
        if (n <= OUT_W) result = OUT_W'(vz << (OUT_W - n));
        else            result = OUT_W'(vz >> (n - OUT_W));
      end
      default: result = vz[OUT_W-1:0];
    endcase

    ovf  = (n > OUT_W);
    rsvd = (mode == IMM_RSVD);
  end

endmodule

// File: rtl/imm_extend_unit.sv
// Chunked immediate accumulator with zero/sign/high extension and a registered
// valid/ready result stage.
module imm_extend_unit
  import imm_ext_pkg::*;
#(
  parameter int IN_W       = 8,
  parameter int OUT_W      = 20,
  parameter int MAX_CHUNKS = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_last,
  input  logic [1:0]       in_mode,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_ovf,
  output logic             out_err
);

  localparam int VW = IN_W * MAX_CHUNKS;
  localparam int CW = $clog2(MAX_CHUNKS + 1);

  // Handshake: a transfer occurs on a side when its valid and ready are both high
  // at the rising edge; ready never looks at valid, and a held result may be
  // replaced in the same cycle it is consumed.
  imm_state_e      state;
  logic [VW-1:0]   acc;
  logic [CW-1:0]   count;
  logic [CW-1:0]   cnt_inc;
  logic [VW-1:0]   v_cat;
  logic            accept;
  logic            completing;
  logic [OUT_W-1:0] core_result;
  logic            core_ovf;
  logic            core_rsvd;

  assign in_ready   = !out_valid || out_ready;
  assign accept     = in_valid && in_ready && !flush;
  assign cnt_inc    = count + CW'(1);
  assign completing = in_last || (cnt_inc == CW'(MAX_CHUNKS));
  assign v_cat      = (acc << IN_W) | VW'(in_data);

  imm_ext_core #(
    .IN_W      (IN_W),
    .OUT_W     (OUT_W),
    .MAX_CHUNKS(MAX_CHUNKS)
  ) u_core (
    .v     (v_cat),
    .count (cnt_inc),
    .mode  (imm_mode_e'(in_mode)),
    .result(core_result),
    .ovf   (core_ovf),
    .rsvd  (core_rsvd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      acc       <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      if (flush) begin
        state <= ST_IDLE;
        acc   <= '0;
        count <= '0;
      end else if (accept) begin
        if (completing) begin
          state <= ST_IDLE;
          acc   <= '0;
          count <= '0;
        end else begin
          state <= ST_ACCUM;
          acc   <= v_cat;
          count <= cnt_inc;
        end
      end

      // Reload wins over drain so back-to-back results stream at one per cycle.
      if (accept && completing) begin
        out_valid <= 1'b1;
        out_data  <= core_result;
        out_ovf   <= core_ovf;
        out_err   <= core_rsvd || !in_last;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
